tone_sequencer: RTL and testbench

Plays a programmable melody on the audio tone generator. A 16-entry note table holds one (frequency, duration) pair per entry. On a start pulse the block steps through the table, driving the tone generator's `freq` and `output_enable` inputs for each note and inserting a short silent gap between notes. It sits between user controls (buttons/switches) and `tone_generator` in the top level, replacing direct button-to-frequency wiring.

---
 rtl/tone_sequencer_if.sv | 26 ++
 rtl/tone_sequencer.sv | 150 +++++++++++++++
 tb/tb_tone_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// Control/table-write bus between the user-control logic and tone_sequencer,
// plus the tone generator drive outputs.
interface tone_sequencer_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [23:0] wr_freq;
  logic [3:0]  wr_beats;
  logic        start;
  logic        stop;
  logic        loop;
  logic [23:0] freq;
  logic        output_enable;
  logic        busy;
  logic [3:0]  note_idx;
  logic        done;

  modport master (
    output wr_en, wr_addr, wr_freq, wr_beats, start, stop, loop,
    input  freq, output_enable, busy, note_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_freq, wr_beats, start, stop, loop,
    output freq, output_enable, busy, note_idx, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// Steps through a 16-entry (freq, beats) note table and drives the tone generator,
// inserting a silent gap after every note.
module tone_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 12_500_000,
  parameter int unsigned GAP_TICKS      = 1_250_000
) (
  input logic             clk,
  input logic             rst,
  tone_sequencer_if.slave bus
);
  localparam int unsigned CntMax = (TICKS_PER_BEAT > GAP_TICKS) ?
                                   ((TICKS_PER_BEAT > 2) ? TICKS_PER_BEAT : 2) :
                                   ((GAP_TICKS > 2) ? GAP_TICKS : 2);
  localparam int unsigned CntW = $clog2(CntMax);
  localparam logic [CntW-1:0] TickLast = CntW'(TICKS_PER_BEAT - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StPlay, StGap} state_e;

  state_e          state_q, state_d;
  logic [27:0]     table_q [16];
  logic [27:0]     table_d [16];
  logic [23:0]     freq_q, freq_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic [3:0]      idx_q, idx_d;
  logic            done_q, done_d;
  logic [3:0]      beat_q, beat_d;
  logic [CntW-1:0] tick_q, tick_d;

  logic [23:0] ent_freq;
  logic [3:0]  ent_beats;
  logic        do_adv, do_end;

  always_comb begin
    table_d   = table_q;
    state_d   = state_q;
    freq_d    = freq_q;
    oe_d      = oe_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    beat_d    = beat_q;
    tick_d    = tick_q;
    do_adv    = 1'b0;
    do_end    = 1'b0;
    // Table reads use table_q, so a same-cycle write to the fetched entry returns old data.
    ent_freq  = table_q[idx_q][27:4];
    ent_beats = table_q[idx_q][3:0];
    if (bus.wr_en) table_d[bus.wr_addr] = {bus.wr_freq, bus.wr_beats};

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          idx_d   = 4'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (ent_beats == 4'd0) begin
          do_end = 1'b1;
        end else begin
          beat_d  = ent_beats;
          tick_d  = '0;
          freq_d  = ent_freq;
          oe_d    = (ent_freq != 24'd0);
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          beat_d = beat_q - 4'd1;
          if (beat_q == 4'd1) begin
            oe_d = 1'b0;
            if (GAP_TICKS == 0) do_adv = 1'b1;
            else                state_d = StGap;
          end
        end else begin
          tick_d = tick_q + CntW'(1);
        end
      end
      StGap: begin
        if (tick_q == GapLast) do_adv = 1'b1;
        else                   tick_d = tick_q + CntW'(1);
      end
    endcase

    if (do_adv) begin
      if (idx_q == 4'd15) begin
        do_end = 1'b1;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = StFetch;
      end
    end

    // Looping requires a playable entry 0, otherwise the song would spin with zero length.
    if (do_end) begin
      if (bus.loop && (table_q[0][3:0] != 4'd0)) begin
        idx_d   = 4'd0;
        state_d = StFetch;
      end else begin
        done_d  = 1'b1;
        freq_d  = 24'd0;
        oe_d    = 1'b0;
        state_d = StIdle;
      end
    end

    if (bus.stop && (state_q != StIdle)) begin
      state_d = StIdle;
      freq_d  = 24'd0;
      oe_d    = 1'b0;
      done_d  = 1'b0;
      idx_d   = idx_q;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      table_q <= '{default: '0};
      freq_q  <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      beat_q  <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      freq_q  <= freq_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      beat_q  <= beat_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.freq          = freq_q;
  assign bus.output_enable = oe_q;
  assign bus.busy          = busy_q;
  assign bus.note_idx      = idx_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: unrolls each song from a shadow note table into an expected
// per-cycle output timeline and compares the DUT against it every cycle.
module tb_tone_sequencer;
  localparam int TPB = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tone_sequencer_if bus ();

  tone_sequencer #(
    .TICKS_PER_BEAT(TPB),
    .GAP_TICKS     (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [27:0] ref_tbl [16];
  logic [31:0] exp_q [$];
  int          ends_q [$];
  int busy_cnt, done_cnt, done_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic oe, input logic [23:0] f, input logic [3:0] i,
                                     input logic b, input logic d);
    return {1'b0, oe, f, i, b, d};
  endfunction

  function automatic logic [31:0] out_now();
    return pk(bus.output_enable, bus.freq, bus.note_idx, bus.busy, bus.done);
  endfunction

  // Expected outputs per cycle, starting with the cycle right after start is sampled.
  // Loop is treated as high for the first loop_ends end-of-song decisions.
  function automatic void build(input int loop_ends);
    int idx = 0;
    int nloops = 0;
    int b;
    bit fin = 0;
    logic [23:0] fh = 24'h0;
    logic [23:0] f;
    exp_q.delete();
    ends_q.delete();
    while (!fin) begin
      exp_q.push_back(pk(1'b0, fh, idx[3:0], 1'b1, 1'b0));
      f = ref_tbl[idx][27:4];
      b = int'(ref_tbl[idx][3:0]);
      if (b != 0) begin
        fh = f;
        repeat (b * TPB) exp_q.push_back(pk(f != 24'h0, fh, idx[3:0], 1'b1, 1'b0));
        repeat (GAP) exp_q.push_back(pk(1'b0, fh, idx[3:0], 1'b1, 1'b0));
        if (idx < 15) begin
          idx++;
          continue;
        end
      end
      ends_q.push_back(exp_q.size() - 1);
      if (nloops < loop_ends && ref_tbl[0][3:0] != 4'd0) begin
        nloops++;
        idx = 0;
      end else begin
        exp_q.push_back(pk(1'b0, 24'h0, idx[3:0], 1'b0, 1'b1));
        fin = 1;
      end
    end
  endfunction

  task automatic wr(input int a, input logic [23:0] f, input logic [3:0] b);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = a[3:0];
    bus.wr_freq  = f;
    bus.wr_beats = b;
    @(negedge clk);
    bus.wr_en = 1'b0;
    ref_tbl[a] = {f, b};
  endtask

  // Plays the song described by exp_q; optional stop (with start if both) in cycle stop_at.
  task automatic play(input int loop_ends, input int stop_at, input bit both);
    busy_cnt = 0;
    done_cnt = 0;
    done_t   = -1;
    bus.loop  = (loop_ends > 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      check("song", out_now(), exp_q[t]);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_t = t;
      end
      if (t == stop_at) begin
        bus.stop  = 1'b1;
        bus.start = both;
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        bus.loop  = 1'b0;
        check("stop", out_now(), pk(1'b0, 24'h0, exp_q[t][5:2], 1'b0, 1'b0));
        @(negedge clk);
        check("stop_hold", out_now(), pk(1'b0, 24'h0, exp_q[t][5:2], 1'b0, 1'b0));
        return;
      end
      if (loop_ends > 0 && ends_q.size() >= loop_ends && t == ends_q[loop_ends-1] + 1)
        bus.loop = 1'b0;
      @(negedge clk);
    end
    bus.loop = 1'b0;
    check("idle_after", out_now(), pk(1'b0, 24'h0, exp_q[exp_q.size()-1][5:2], 1'b0, 1'b0));
  endtask

  initial begin
    int n, stop_at;
    logic [23:0] f;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_freq = '0; bus.wr_beats = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    for (int i = 0; i < 16; i++) ref_tbl[i] = '0;
    repeat (2) @(negedge clk);
    check("reset", out_now(), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single note
    wr(0, 24'h1000, 4'd2);
    wr(1, 24'h0, 4'd0);
    build(0);
    play(0, -1, 0);
    check("single_done_cnt", 32'(done_cnt), 32'd1);

    // Rest and sequence
    wr(0, 24'h800, 4'd1);
    wr(1, 24'h0, 4'd1);
    wr(2, 24'h400, 4'd3);
    wr(3, 24'h0, 4'd0);
    build(0);
    play(0, -1, 0);

    // Full table, no end marker
    for (int i = 0; i < 16; i++) wr(i, 24'h100 + 24'(i), 4'd1);
    build(0);
    play(0, -1, 0);
    check("full_busy", 32'(busy_cnt), 32'(16 * 7));
    check("full_done_cnt", 32'(done_cnt), 32'd1);
    check("full_latency", 32'(done_t + 1), 32'(16 * 7 + 1));

    // Loop over two notes three times, then drop loop
    wr(0, 24'h321, 4'd1);
    wr(1, 24'h654, 4'd2);
    wr(2, 24'h0, 4'd0);
    build(3);
    play(3, -1, 0);
    check("loop_done_cnt", 32'(done_cnt), 32'd1);

    // Stop mid-note, and start+stop together mid-song
    build(0);
    play(0, 4, 0);
    play(0, 9, 1);

    // start+stop together in idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("idle_start_stop", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    check("idle_start_stop2", {31'b0, bus.busy}, 32'h0);

    // Randomized songs
    for (int s = 0; s < 14; s++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        f = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
        wr(i, f, 4'($urandom_range(1, 3)));
      end
      wr(n, 24'($urandom), 4'd0);
      build($urandom_range(0, 2));
      stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, exp_q.size() - 2) : -1;
      play(ends_q.size() > 1 ? ends_q.size() - 1 : 0, stop_at, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-PLAY
    wr(0, 24'h777, 4'd3);
    wr(1, 24'h0, 4'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_oe", {31'b0, bus.output_enable}, 32'h1);
    #2 rst = 1'b1;
    #1 check("async_reset", out_now(), 32'h0);
    for (int i = 0; i < 16; i++) ref_tbl[i] = '0;
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    build(0);
    play(0, -1, 0);
    check("empty_done_at", 32'(done_t), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
